secure_lockout_ctrl: RTL
========================

// Module: secure_lockout_ctrl
// PURPOSE
//   Downstream of the 4-bit code comparator (s vs p -> go/stop). Consumes one
//   go/stop verdict per attempt, opens the door for a fixed window on a match,
//   counts consecutive mismatches and enters a timed lockout with alarm once
//   MAX_FAILS is reached. Holds all access-policy state for the security system.
// PARAMETERS
//   MAX_FAILS      3   consecutive failures that trigger lockout (>=1)
//   UNLOCK_CYCLES  8   cycles unlock stays high after a match (>=1)
//   LOCKOUT_CYCLES 16  cycles locked_out stays high (>=1)
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   attempt_valid  in   1   comparator verdict (go/stop) is valid this cycle
//   go             in   1   comparator: code matched
//   stop           in   1   comparator: code mismatched
//   clr            in   1   sync admin clear: abort window/lockout, zero fail_cnt
//   attempt_ready  out  1   high only in IDLE; attempt accepted = valid & ready
//   unlock         out  1   door release, high for UNLOCK_CYCLES
//   locked_out     out  1   lockout in progress, high for LOCKOUT_CYCLES
//   alarm          out  1   one-cycle pulse on lockout entry
//   fail_cnt       out  $clog2(MAX_FAILS+1)  consecutive failure count
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, timer 0, fail_cnt 0, unlock 0,
//     locked_out 0, alarm 0; attempt_ready=1 after release. All outputs registered
//     except attempt_ready (decoded from state).
//   States: IDLE, OPEN, LOCKOUT.
//   Verdict decode on accepted attempt: match = go & ~stop. Anything else
//     (stop only, go&stop both high, neither high) counts as a failure.
//   IDLE, accepted match: -> OPEN; fail_cnt<=0; timer<=UNLOCK_CYCLES-1; unlock=1
//     from the next cycle (1-cycle latency).
//   IDLE, accepted failure: fail_cnt+1. If new count == MAX_FAILS -> LOCKOUT;
//     timer<=LOCKOUT_CYCLES-1; locked_out=1 and alarm=1 next cycle; fail_cnt holds
//     MAX_FAILS through lockout (saturates, never wraps).
//   OPEN: unlock=1; timer decrements each cycle; when timer==0 -> IDLE, unlock=0
//     next cycle. Exactly UNLOCK_CYCLES cycles of unlock.
//   LOCKOUT: locked_out=1; alarm only on first cycle; timer decrements; when
//     timer==0 -> IDLE, fail_cnt<=0, locked_out=0. Exactly LOCKOUT_CYCLES cycles.
//   attempt_valid outside IDLE is ignored (not counted, no state change).
//   clr (any state): -> IDLE, fail_cnt<=0, timer<=0, unlock/locked_out/alarm<=0
//     next cycle. clr and accepted attempt in the same cycle: clr wins, attempt
//     dropped.
//   Reset mid-OPEN or mid-LOCKOUT: immediate return to reset values; no
//     residual count.
//   Timer width = $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)); UNLOCK/LOCKOUT=1
//     gives a single-cycle window.
// TESTING
//   Reset, valid=1 go=1 stop=0 for 1 cycle -> unlock high 8 cycles starting next
//     cycle, fail_cnt=0, attempt_ready=0 during window.
//   Three failures (go=0 stop=1) in IDLE -> fail_cnt 1,2 then LOCKOUT: alarm 1-cycle
//     pulse, locked_out high 16 cycles, fail_cnt=3, then returns 0, ready=1.
//   Two failures then a match -> fail_cnt 1,2 then 0 with unlock window; a later
//     single failure gives fail_cnt=1 (no lockout).
//   go=1 stop=1 and go=0 stop=0 with valid -> each counted as failure.
//   Attempts during OPEN/LOCKOUT -> ignored; clr on cycle 5 of lockout ->
//     locked_out=0, fail_cnt=0 next cycle; clr with same-cycle match -> no unlock.
//   rst_n low mid-lockout (async, between edges) -> outputs zero immediately.

Source files
------------

// File: rtl/secure_lockout_ctrl.sv
// Access-policy controller behind the code comparator. It opens a timed unlock window
// on a match and counts consecutive failures into a timed lockout with an alarm pulse.
//
// state   | meaning
// IDLE    | waiting for a comparator verdict, attempt_ready high
// OPEN    | door released, unlock held for UNLOCK_CYCLES
// LOCKOUT | too many failures, locked_out held for LOCKOUT_CYCLES
module secure_lockout_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int FW   = $clog2(MAX_FAILS + 1),
  localparam int MAXC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES,
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          attempt_valid,
  input  logic          go,
  input  logic          stop,
  input  logic          clr,
  output logic          attempt_ready,
  output logic          unlock,
  output logic          locked_out,
  output logic          alarm,
  output logic [FW-1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

  localparam logic [FW-1:0] MAX_F      = FW'(MAX_FAILS);
  localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [FW-1:0] r_fail_cnt;
  logic          r_unlock;
  logic          r_locked_out;
  logic          r_alarm;

  logic          w_accept;
  logic          w_match;
  logic [FW-1:0] w_fail_inc;

  assign attempt_ready = (r_state == IDLE);
  assign w_accept      = attempt_valid & attempt_ready;
  // Only a clean go counts as a match; conflicting or empty verdicts are failures.
  assign w_match       = go & ~stop;
  // fail_cnt stays below MAX_FAILS while in IDLE, so this never wraps.
  assign w_fail_inc    = r_fail_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_fail_cnt   <= '0;
      r_unlock     <= 1'b0;
      r_locked_out <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
      if (clr) begin
        r_state      <= IDLE;
        r_timer      <= '0;
        r_fail_cnt   <= '0;
        r_unlock     <= 1'b0;
        r_locked_out <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (w_match) begin
                r_state    <= OPEN;
                r_fail_cnt <= '0;
                r_timer    <= UNLOCK_LD;
                r_unlock   <= 1'b1;
              end else if (w_fail_inc == MAX_F) begin
                r_state      <= LOCKOUT;
                r_fail_cnt   <= MAX_F;
                r_timer      <= LOCKOUT_LD;
                r_locked_out <= 1'b1;
                r_alarm      <= 1'b1;
              end else begin
                r_fail_cnt <= w_fail_inc;
              end
            end
          end
          OPEN: begin
            if (r_timer == '0) begin
              r_state  <= IDLE;
              r_unlock <= 1'b0;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          LOCKOUT: begin
            if (r_timer == '0) begin
              r_state      <= IDLE;
              r_fail_cnt   <= '0;
              r_locked_out <= 1'b0;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          default: begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_fail_cnt   <= '0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
          end
        endcase
      end
    end
  end

  assign unlock     = r_unlock;
  assign locked_out = r_locked_out;
  assign alarm      = r_alarm;
  assign fail_cnt   = r_fail_cnt;

endmodule
